tick_led_seq: RTL and testbench

- Consumes the slow square wave produced by the clock divider and drives an LED pattern from it.
- Treats that wave as data, not as a clock. It is synchronised into the clk_in domain and rising-edge detected, which yields a one-cycle tick.
- A pattern state machine advances once per tick. The state machine is one of: off, blink, chase, bounce.
- Sits between the divider and the board LED pins.

---
 rtl/led_seq_pkg.sv | 34 +++
 rtl/sync_rise_det.sv | 41 ++++
 rtl/tick_led_seq.sv | 105 ++++++++++
 tb/tb_tick_led_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared encodings for the tick-driven LED pattern sequencer.
package led_seq_pkg;

  // Requested and applied pattern modes as seen on mode_in / mode_out.
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  // Pattern FSM states; bounce carries its travel direction in the state.
  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StBlink    = 3'd1,
    StChase    = 3'd2,
    StBounceUp = 3'd3,
    StBounceDn = 3'd4
  } led_state_e;

  // Mode reported for a given FSM state; both bounce directions are one mode.
  function automatic logic [1:0] state_mode(input led_state_e st);
    logic [1:0] m;
    m = MODE_OFF;
    unique case (st)
      StOff:      m = MODE_OFF;
      StBlink:    m = MODE_BLINK;
      StChase:    m = MODE_CHASE;
      StBounceUp: m = MODE_BOUNCE;
      StBounceDn: m = MODE_BOUNCE;
      default:    m = MODE_OFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchroniser for a slow asynchronous input followed by a
// registered rising-edge detector producing a one-cycle pulse.
module sync_rise_det #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic sig_in,
  output logic rise_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise_q;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain; bit 0 is the first stage.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  // History is reset low so an input already high at reset release yields one pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hist_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      hist_q <= sync_last;
      rise_q <= sync_last & ~hist_q;
    end
  end

  assign rise_out = rise_q;

endmodule

// File: rtl/tick_led_seq.sv
// LED pattern sequencer advanced by rising edges of a divided square wave that
// is sampled as data in the clk_in domain.
module tick_led_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LEDS      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              slow_in,
  input  logic              en_in,
  input  logic [1:0]        mode_in,
  output logic              tick_out,
  output logic [N_LEDS-1:0] leds_out,
  output logic [1:0]        mode_out
);

  localparam logic [N_LEDS-1:0] LedBit0 = N_LEDS'(1);

  led_state_e        state_q, state_d;
  logic [N_LEDS-1:0] leds_q, leds_d;
  logic              tick;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_rise_det (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .sig_in  (slow_in),
    .rise_out(tick)
  );

  // Rotate left by one; degenerates to identity for a single LED.
  function automatic logic [N_LEDS-1:0] rotl1(input logic [N_LEDS-1:0] v);
    return (v << 1) | (v >> (N_LEDS - 1));
  endfunction

  // Next pattern and state, evaluated only on an enabled tick.
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    if (tick && en_in) begin
      if (mode_in != state_mode(state_q)) begin
        unique case (mode_in)
          MODE_OFF: begin
            state_d = StOff;
            leds_d  = '0;
          end
          MODE_BLINK: begin
            state_d = StBlink;
            leds_d  = '1;
          end
          MODE_CHASE: begin
            state_d = StChase;
            leds_d  = LedBit0;
          end
          MODE_BOUNCE: begin
            state_d = StBounceUp;
            leds_d  = LedBit0;
          end
          default: begin
            state_d = StOff;
            leds_d  = '0;
          end
        endcase
      end else begin
        unique case (state_q)
          StOff:   leds_d = '0;
          StBlink: leds_d = ~leds_q;
          StChase: leds_d = rotl1(leds_q);
          StBounceUp: begin
            leds_d = (N_LEDS == 1) ? leds_q : (leds_q << 1);
            // Turn around as soon as the top bit is lit so it shows for one tick.
            if (leds_d[N_LEDS-1] && N_LEDS > 1) state_d = StBounceDn;
          end
          StBounceDn: begin
            leds_d = (N_LEDS == 1) ? leds_q : (leds_q >> 1);
            if (leds_d[0]) state_d = StBounceUp;
          end
          default: begin
            state_d = StOff;
            leds_d  = '0;
          end
        endcase
      end
    end
  end

  // Pattern state and LED register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StOff;
      leds_q  <= '0;
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
    end
  end

  assign tick_out = tick;
  assign leds_out = leds_q;
  assign mode_out = state_mode(state_q);

endmodule

// File: tb/tb_tick_led_seq.sv
// Self-checking bench for tick_led_seq: directed pattern scenarios plus random
// slow_in / en_in / mode_in traffic compared each cycle against a reference model.
module tb_tick_led_seq;

  localparam int NL = 4;
  localparam int SS = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          slow_in;
  logic          en_in;
  logic [1:0]    mode_in;
  logic          tick_out;
  logic [NL-1:0] leds_out;
  logic [1:0]    mode_out;

  int checks   = 0;
  int failures = 0;

  // Reference model: pattern as mode + LED position/direction/blink phase,
  // tick as a function of the last few sampled slow_in values.
  bit m_tick;
  int m_mode;
  int m_pos;
  bit m_up;
  bit m_blink;
  bit sq[$];

  tick_led_seq #(
    .N_LEDS     (NL),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .slow_in (slow_in),
    .en_in   (en_in),
    .mode_in (mode_in),
    .tick_out(tick_out),
    .leds_out(leds_out),
    .mode_out(mode_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tick  = 1'b0;
    m_mode  = 0;
    m_pos   = 0;
    m_up    = 1'b1;
    m_blink = 1'b0;
    sq.delete();
    repeat (4) sq.push_back(1'b0);
  endtask

  function automatic logic [NL-1:0] exp_leds();
    logic [NL-1:0] v;
    case (m_mode)
      0:       v = '0;
      1:       v = m_blink ? {NL{1'b1}} : '0;
      default: v = NL'(1 << m_pos);
    endcase
    return v;
  endfunction

  task automatic model_edge();
    if (m_tick && en_in) begin
      if (int'(mode_in) != m_mode) begin
        m_mode  = int'(mode_in);
        m_pos   = 0;
        m_up    = 1'b1;
        m_blink = 1'b1;
      end else begin
        case (m_mode)
          1: m_blink = !m_blink;
          2: m_pos = (m_pos + 1) % NL;
          3: begin
            m_pos = m_pos + (m_up ? 1 : -1);
            if (m_pos == NL - 1) m_up = 1'b0;
            else if (m_pos == 0) m_up = 1'b1;
          end
          default: ;
        endcase
      end
    end
    // Tick after edge e reflects a 0->1 between the samples taken at edges e-3 and e-2.
    sq.push_back(slow_in);
    void'(sq.pop_front());
    m_tick = sq[1] & ~sq[0];
  endtask

  // One clock: advance the model at the edge, compare all outputs just after it.
  task automatic cycle();
    logic [1:0] em;
    @(posedge clk_in);
    if (!rst_in) model_edge();
    #1;
    em = 2'(m_mode);
    check_eq("tick_out", 32'(tick_out), 32'(m_tick));
    check_eq("leds_out", 32'(leds_out), 32'(exp_leds()));
    check_eq("mode_out", 32'(mode_out), 32'(em));
  endtask

  // Raise slow_in for 4 cycles then lower it for 4; report tick latency and count.
  task automatic do_tick(output int lat, output int nt);
    lat = 0;
    nt  = 0;
    slow_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) slow_in = 1'b0;
      cycle();
      if (tick_out) begin
        nt++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  task automatic tick_and_check(input string tag, input logic [NL-1:0] exp_l);
    int lat, nt;
    do_tick(lat, nt);
    check_eq("tick_latency", 32'(lat), 32'd3);
    check_eq("tick_count", 32'(nt), 32'd1);
    check_eq(tag, 32'(leds_out), 32'(exp_l));
  endtask

  initial begin
    logic [NL-1:0] chase_tbl [5];
    logic [NL-1:0] bounce_tbl [8];
    int lat, nt;
    chase_tbl  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bounce_tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    rst_in  = 1'b1;
    slow_in = 1'b0;
    en_in   = 1'b0;
    mode_in = 2'd0;
    model_reset();
    repeat (3) cycle();
    check_eq("reset_leds", 32'(leds_out), 32'd0);
    rst_in = 1'b0;
    repeat (3) cycle();

    // Chase entry, advance and wrap.
    en_in   = 1'b1;
    mode_in = 2'd2;
    for (int i = 0; i < 5; i++) begin
      tick_and_check("chase_leds", chase_tbl[i]);
      if (i == 0) check_eq("chase_mode", 32'(mode_out), 32'd2);
    end

    // Bounce: each end bit shown for one tick.
    mode_in = 2'd3;
    for (int i = 0; i < 8; i++) tick_and_check("bounce_leds", bounce_tbl[i]);

    // Blink, then frozen by en_in=0 while ticks continue.
    mode_in = 2'd1;
    tick_and_check("blink_on", 4'b1111);
    tick_and_check("blink_off", 4'b0000);
    en_in = 1'b0;
    for (int i = 0; i < 3; i++) tick_and_check("blink_hold", 4'b0000);
    en_in = 1'b1;
    tick_and_check("blink_resume", 4'b1111);

    // Reset release with slow_in already high: one tick, 3 edges after release.
    #2;
    rst_in  = 1'b1;
    slow_in = 1'b1;
    model_reset();
    #1;
    check_eq("rst_async_leds", 32'(leds_out), 32'd0);
    check_eq("rst_async_mode", 32'(mode_out), 32'd0);
    repeat (3) cycle();
    rst_in = 1'b0;
    lat = 0;
    nt  = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (tick_out) begin
        nt++;
        if (lat == 0) lat = i;
      end
    end
    check_eq("rel_high_latency", 32'(lat), 32'd3);
    check_eq("rel_high_count", 32'(nt), 32'd1);
    slow_in = 1'b0;
    repeat (4) cycle();

    // Reset mid-pattern while bouncing down at 0100.
    en_in   = 1'b1;
    mode_in = 2'd3;
    for (int i = 0; i < 5; i++) tick_and_check("bounce_pre_rst", bounce_tbl[i]);
    slow_in = 1'b1;
    repeat (3) cycle();
    check_eq("tick_before_rst", 32'(tick_out), 32'd1);
    #2;
    rst_in = 1'b1;
    model_reset();
    #1;
    check_eq("mid_rst_leds", 32'(leds_out), 32'd0);
    check_eq("mid_rst_mode", 32'(mode_out), 32'd0);
    check_eq("mid_rst_tick", 32'(tick_out), 32'd0);
    slow_in = 1'b0;
    repeat (2) cycle();
    rst_in = 1'b0;
    repeat (2) cycle();
    tick_and_check("post_rst_load", 4'b0001);
    check_eq("post_rst_mode", 32'(mode_out), 32'd3);

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      slow_in = ~slow_in;
      repeat ($urandom_range(1, 5)) begin
        if ($urandom_range(0, 7) == 0) mode_in = 2'($urandom);
        en_in = ($urandom_range(0, 4) != 0);
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
